md_unit: RTL

- Multiply/divide unit in the execute stage, beside the ALU; consumes the same forwarded operands (rs → A, rt → B).
- Executes mult/multu/div/divu as multi-cycle operations and mthi/mtlo as single-cycle writes.
- Holds the architectural HI/LO registers, which the M-stage result mux reads for mfhi/mflo.
- The hazard unit stalls the pipeline while Busy is high.

---
 rtl/md_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO registers.
// Multi-cycle ops run for a fixed count of cycles; mthi/mtlo write in one cycle.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cancel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt, cnt_nx;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        accept, load, commit, is_md;
    logic [63:0] prod_s, prod_u;
    logic [31:0] q_s, r_s, q_u, r_u;

    // Handshake: a command is taken at a rising edge when Start=1, Cancel=0 and
    // Busy=0; while Busy=1 any Start is dropped, so the issuer must stall.
    assign accept = Start && !Cancel && (state == IDLE);
    assign is_md  = (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
    assign Busy   = (state == BUSY);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load     = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_md) begin
                    state_nx = BUSY;
                    load     = 1'b1;
                    cnt_nx   = (MDOp <= OP_MULTU) ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
                end
            end
            BUSY: begin
                if (cnt <= 5'd1) begin
                    state_nx = IDLE;
                    commit   = 1'b1;
                    cnt_nx   = 5'd0;
                end else begin
                    cnt_nx = cnt - 5'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    // The most-negative / -1 quotient overflows; it wraps to the dividend.
    always_comb begin
        q_s = '0;
        r_s = '0;
        q_u = '0;
        r_u = '0;
        if (b_q != 32'd0) begin
            q_u = a_q / b_q;
            r_u = a_q % b_q;
            if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                q_s = a_q;
                r_s = '0;
            end else begin
                q_s = $signed(a_q) / $signed(b_q);
                r_s = $signed(a_q) % $signed(b_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (load) begin
                op_q <= MDOp;
                a_q  <= A;
                b_q  <= B;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI <= '0;
            LO <= '0;
        end else if (commit) begin
            case (op_q)
                OP_MULT:  {HI, LO} <= prod_s;
                OP_MULTU: {HI, LO} <= prod_u;
                OP_DIV:   if (b_q != 32'd0) begin HI <= r_s; LO <= q_s; end
                OP_DIVU:  if (b_q != 32'd0) begin HI <= r_u; LO <= q_u; end
                default: ;
            endcase
        end else if (accept && MDOp == OP_MTHI) begin
            HI <= A;
        end else if (accept && MDOp == OP_MTLO) begin
            LO <= A;
        end
    end

endmodule
